// File: rtl/h264_feeder_pkg.sv
// rtl/h264_feeder_pkg.sv - shared constants, drain states and reorder map for the intra 8x8 chroma feeder
package h264_feeder_pkg;

    localparam int MB_WORDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } drain_state_t;

    // Read index -> raster word address: {comp, by, rib[1:0], bx}
    function automatic logic [4:0] reorder_addr(input logic [4:0] r);
        return {r[4], r[3], r[1:0], r[2]};
    endfunction

endpackage

// File: rtl/h264_intra8x8cc_feeder_if.sv
// rtl/h264_intra8x8cc_feeder_if.sv - pixel input and predictor output signals of the chroma feeder
interface h264_intra8x8cc_feeder_if;
    logic        SLICESTART;
    logic        PIXVALID;
    logic [31:0] PIXI;
    logic        PIXREADY;
    logic        READYI;
    logic        STROBEI;
    logic [31:0] DATAI;
    logic        NEWLINE;
    logic        NEWSLICE;

    modport master (
        output SLICESTART, PIXVALID, PIXI, READYI,
        input  PIXREADY, STROBEI, DATAI, NEWLINE, NEWSLICE
    );

    modport slave (
        input  SLICESTART, PIXVALID, PIXI, READYI,
        output PIXREADY, STROBEI, DATAI, NEWLINE, NEWSLICE
    );
endinterface

// File: rtl/h264_feeder_bank_ram.sv
// rtl/h264_feeder_bank_ram.sv - 64x32 simple dual-port RAM, bank select in address MSB, synchronous read
module h264_feeder_bank_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem [64];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/h264_intra8x8cc_feeder.sv
// rtl/h264_intra8x8cc_feeder.sv - double-buffered raster-to-4x4 reorder feeder for the intra 8x8 chroma predictor
// Optional MB counter output enabled by FEEDER_STATS_EN.
module h264_intra8x8cc_feeder
    import h264_feeder_pkg::*;
#(
    parameter int MB_WIDTH = 22
) (
    input  logic CLK2,
    input  logic RESET,
    h264_intra8x8cc_feeder_if.slave bus
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0] MBCOUNT
`endif
);
    localparam int MBX_W = (MB_WIDTH > 1) ? $clog2(MB_WIDTH) : 1;

    drain_state_t state, state_d;

    logic             in_en;
    logic             wr_bank, rd_bank;
    logic [4:0]       wr_cnt, rd_cnt;
    logic [1:0]       full, tag;
    logic             pending;
    logic [MBX_W-1:0] mbx, mbx_eff;
    logic             accept, wr_last, rd_last, sending;
    logic [31:0]      ram_rdata;
    logic             s1_valid, s1_first, s1_line, s1_slice, s1_last;

    assign accept       = bus.PIXVALID & bus.PIXREADY;
    assign wr_last      = accept && (wr_cnt == 5'(MB_WORDS - 1));
    assign sending      = (state == SEND);
    assign rd_last      = sending && (rd_cnt == 5'(MB_WORDS - 1));
    assign bus.PIXREADY = in_en & ~(&full);
    // A slice always starts a picture row, so a tagged MB restarts the column count
    assign mbx_eff      = tag[rd_bank] ? '0 : mbx;

    h264_feeder_bank_ram u_ram (
        .clk   (CLK2),
        .we    (accept),
        .waddr ({wr_bank, wr_cnt}),
        .wdata (bus.PIXI),
        .raddr ({rd_bank, reorder_addr(rd_cnt)}),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (|full) state_d = WAIT;
            WAIT: if (bus.READYI) state_d = SEND;
            SEND: begin
                if (rd_cnt == 5'(MB_WORDS - 1)) begin
                    if (full[~rd_bank] && bus.READYI) state_d = SEND;
                    else if (full[~rd_bank])          state_d = WAIT;
                    else                              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            in_en   <= 1'b0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            pending <= 1'b0;
            tag     <= '0;
            full    <= '0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            mbx     <= '0;
        end else begin
            in_en <= 1'b1;
            if (bus.SLICESTART) begin
                pending <= 1'b1;
            end
            if (accept) begin
                wr_cnt <= wr_cnt + 5'd1;
                if (wr_cnt == 5'd0) begin
                    tag[wr_bank] <= pending | bus.SLICESTART;
                    pending      <= 1'b0;
                end
                if (wr_last) begin
                    wr_bank       <= ~wr_bank;
                    full[wr_bank] <= 1'b1;
                end
            end
            // The write bank is never the bank being drained, so these bits never collide
            if (sending) begin
                rd_cnt <= rd_cnt + 5'd1;
                if (rd_last) begin
                    rd_bank       <= ~rd_bank;
                    full[rd_bank] <= 1'b0;
                    mbx           <= (mbx_eff == MBX_W'(MB_WIDTH - 1)) ? '0 : mbx_eff + 1'b1;
                end
            end
        end
    end

    // Stage 1 aligns the flags with the synchronous RAM read; stage 2 drives the outputs
    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_line      <= 1'b0;
            s1_slice     <= 1'b0;
            s1_last      <= 1'b0;
            bus.STROBEI  <= 1'b0;
            bus.DATAI    <= '0;
            bus.NEWLINE  <= 1'b0;
            bus.NEWSLICE <= 1'b0;
        end else begin
            s1_valid     <= sending;
            s1_first     <= sending && (rd_cnt == 5'd0);
            s1_line      <= (mbx_eff == '0);
            s1_slice     <= tag[rd_bank];
            s1_last      <= rd_last;
            bus.STROBEI  <= s1_valid;
            bus.DATAI    <= s1_valid ? ram_rdata : '0;
            bus.NEWLINE  <= s1_valid & s1_first & s1_line;
            bus.NEWSLICE <= s1_valid & s1_first & s1_slice;
        end
    end

`ifdef FEEDER_STATS_EN
    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            MBCOUNT <= '0;
        end else if (s1_valid && s1_last) begin
            MBCOUNT <= MBCOUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_h264_intra8x8cc_feeder.sv
// tb/tb_h264_intra8x8cc_feeder.sv - scoreboard bench for the intra 8x8 chroma feeder
module tb_h264_intra8x8cc_feeder;
    localparam int MBW = 3;

    logic CLK2 = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK2 = ~CLK2;

    h264_intra8x8cc_feeder_if bus ();
`ifdef FEEDER_STATS_EN
    logic [15:0] MBCOUNT;
`endif

    h264_intra8x8cc_feeder #(.MB_WIDTH(MBW)) dut (
        .CLK2  (CLK2),
        .RESET (RESET),
        .bus   (bus)
`ifdef FEEDER_STATS_EN
        ,
        .MBCOUNT (MBCOUNT)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic        nl;
        logic        ns;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int mbx_m = 0;
    int mb_sent_m = 0;
    int strobes = 0;
    int run = 0;
    int max_run = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK2) begin : monitor
        exp_t e;
        if (RESET) begin
            run = 0;
        end else if (bus.STROBEI) begin
            strobes++;
            run++;
            if (run > max_run) max_run = run;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check("word", longint'({bus.DATAI, bus.NEWLINE, bus.NEWSLICE}), longint'(e));
            end
        end else begin
            run = 0;
        end
    end

    task automatic put_word(input logic [31:0] d, output bit ok);
        int t;
        t = 0;
        bus.PIXVALID = 1'b1;
        bus.PIXI     = d;
        while (!bus.PIXREADY && t < 3000) begin
            @(negedge CLK2);
            t++;
        end
        @(negedge CLK2);
        bus.PIXVALID = 1'b0;
        ok = (t < 3000);
    endtask

    // Reference: output word r of an MB is pixel-row word of 4x4 block r/4 in Cb then Cr
    task automatic send_mb(input bit seq, input bit slice);
        logic [31:0] w [32];
        int eff;
        bit ok;
        for (int i = 0; i < 32; i++) w[i] = seq ? 32'(i) : 32'($urandom);
        if (slice) begin
            bus.SLICESTART = 1'b1;
            @(negedge CLK2);
            bus.SLICESTART = 1'b0;
        end
        eff = slice ? 0 : mbx_m;
        for (int r = 0; r < 32; r++) begin
            int comp, blk, rib, raster;
            comp   = r / 16;
            blk    = (r % 16) / 4;
            rib    = r % 4;
            raster = comp * 16 + ((blk / 2) * 4 + rib) * 2 + (blk % 2);
            sb.push_back('{d: w[raster], nl: (r == 0 && eff == 0), ns: (r == 0 && slice)});
        end
        mbx_m = (eff + 1) % MBW;
        mb_sent_m++;
        for (int i = 0; i < 32; i++) begin
            put_word(w[i], ok);
            if (!ok) begin
                check("pixready_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 3000) begin
            @(negedge CLK2);
            t++;
        end
        check("drain_complete", sb.size(), 0);
        repeat (5) @(negedge CLK2);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int base;
        bus.SLICESTART = 1'b0;
        bus.PIXVALID   = 1'b0;
        bus.PIXI       = '0;
        bus.READYI     = 1'b0;

        RESET = 1'b1;
        repeat (3) @(negedge CLK2);
        check("reset_pixready", bus.PIXREADY, 0);
        check("reset_strobei", bus.STROBEI, 0);
        check("reset_datai", bus.DATAI, 0);
        check("reset_newline", bus.NEWLINE, 0);
        check("reset_newslice", bus.NEWSLICE, 0);
        RESET = 1'b0;
        @(negedge CLK2);
        check("pixready_after_reset", bus.PIXREADY, 1);

        // Single MB with ascending words; measure READYI -> STROBEI latency
        send_mb(1'b1, 1'b0);
        repeat (5) @(negedge CLK2);
        check("no_strobe_without_ready", strobes, 0);
        bus.READYI = 1'b1;
        n = 0;
        while (!bus.STROBEI && n < 20) begin
            @(negedge CLK2);
            n++;
        end
        // sampling edge plus two more edges
        check("ready_to_strobe_latency", n, 3);
        wait_drain();
        check("single_mb_word_count", strobes, 32);

        // Backpressure: two buffered MBs, third stalls until drain starts
        bus.READYI = 1'b0;
        send_mb(1'b0, 1'b0);
        send_mb(1'b0, 1'b0);
        check("pixready_both_full", bus.PIXREADY, 0);
        max_run = 0;
        fork
            send_mb(1'b0, 1'b0);
            begin
                repeat (10) @(negedge CLK2);
                check("third_mb_stalled", bus.PIXREADY, 0);
                check("no_drain_while_not_ready", strobes, 32);
                bus.READYI = 1'b1;
            end
        join
        wait_drain();
        check("back_to_back_run", (max_run >= 64) ? 1 : 0, 1);

        // Row wrap and slice tagging
        for (int k = 0; k < 4; k++) send_mb(1'b0, 1'b0);
        send_mb(1'b0, 1'b1);
        send_mb(1'b0, 1'b0);
        wait_drain();

        // Random READYI with occasional slice starts
        fork
            for (int k = 0; k < 6; k++) send_mb(1'b0, ($urandom_range(0, 3) == 0));
            begin
                repeat (400) begin
                    @(negedge CLK2);
                    bus.READYI = 1'($urandom_range(0, 1));
                end
                bus.READYI = 1'b1;
            end
        join
        wait_drain();
`ifdef FEEDER_STATS_EN
        check("mbcount", MBCOUNT, mb_sent_m % 65536);
`endif

        // Reset in the middle of a drain with another MB buffered
        bus.READYI = 1'b0;
        send_mb(1'b0, 1'b0);
        send_mb(1'b0, 1'b0);
        base = strobes;
        bus.READYI = 1'b1;
        n = 0;
        while (strobes < base + 10 && n < 500) begin
            @(negedge CLK2);
            n++;
        end
        check("mid_send_reached", (strobes >= base + 10) ? 1 : 0, 1);
        #1;
        RESET = 1'b1;
        #1;
        check("strobe_cleared_by_reset", bus.STROBEI, 0);
        sb.delete();
        mbx_m = 0;
        mb_sent_m = 0;
        repeat (3) @(negedge CLK2);
        RESET = 1'b0;
        base = strobes;
        repeat (50) @(negedge CLK2);
        check("no_residual_words", strobes, base);
        check("pixready_after_mid_reset", bus.PIXREADY, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
